// File: rtl/count_pkg.sv
// Shared constants for the modulo-N up/down counter: mode encoding and the
// default geometry used by the bench configuration.
package count_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 12;

endpackage

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with synchronous load, wrap/saturate
// selection, terminal-count output for cascading and one-cycle status pulses.
module modn_updown_counter
  import count_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  // MOD_EXT carries one extra bit so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  always_comb begin
    data_d     = data_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, data_in} < MOD_EXT) begin
        data_d = data_in;
      end else begin
        data_d     = MAX_VAL;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (mode == MODE_UP) begin
        if (data_q == MAX_VAL) begin
          if (!SATURATE) begin
            data_d = '0;
            wrap_d = 1'b1;
          end
        end else begin
          data_d = data_q + WIDTH'(1);
        end
      end else begin
        if (data_q == '0) begin
          if (!SATURATE) begin
            data_d = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          data_d = data_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Not gated by en, so a cascade forms the next stage's enable as en & tc.
  assign tc = (mode == MODE_UP) ? (data_q == MAX_VAL) : (data_q == '0);

  assign data_out = data_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: wrap mode, saturating mode,
// full-range modulus and a two-stage cascade.
module tb_modn_updown_counter;
  import count_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int M = DEF_MODULUS;

  int compared   = 0;
  int mismatched = 0;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main wrapping instance
  logic         en, load, mode;
  logic [W-1:0] data_in, data_out;
  logic         tc, wrap, load_err;

  // Saturating instance
  logic         s_en, s_load, s_mode;
  logic [W-1:0] s_data_in, s_data_out;
  logic         s_tc, s_wrap, s_load_err;

  // Full-range (MODULUS = 2**WIDTH) instance
  logic         f_en, f_load, f_mode;
  logic [W-1:0] f_data_in, f_data_out;
  logic         f_tc, f_wrap, f_load_err;

  // Cascade
  logic         c_en1;
  logic         c_en2;
  logic [W-1:0] c_din;
  logic [W-1:0] c_q1, c_q2;
  logic         c_tc1, c_tc2, c_wrap1, c_wrap2, c_err1, c_err2;

  modn_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode),
    .data_in(data_in), .data_out(data_out), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  modn_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b1)) sat (
    .clk(clk), .reset(reset), .en(s_en), .load(s_load), .mode(s_mode),
    .data_in(s_data_in), .data_out(s_data_out), .tc(s_tc), .wrap(s_wrap), .load_err(s_load_err)
  );

  modn_updown_counter #(.WIDTH(W), .MODULUS(16), .SATURATE(1'b0)) full (
    .clk(clk), .reset(reset), .en(f_en), .load(f_load), .mode(f_mode),
    .data_in(f_data_in), .data_out(f_data_out), .tc(f_tc), .wrap(f_wrap), .load_err(f_load_err)
  );

  assign c_en2 = c_en1 & c_tc1;

  modn_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0)) stage1 (
    .clk(clk), .reset(reset), .en(c_en1), .load(1'b0), .mode(MODE_UP),
    .data_in(c_din), .data_out(c_q1), .tc(c_tc1), .wrap(c_wrap1), .load_err(c_err1)
  );

  modn_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0)) stage2 (
    .clk(clk), .reset(reset), .en(c_en2), .load(1'b0), .mode(MODE_UP),
    .data_in(c_din), .data_out(c_q2), .tc(c_tc2), .wrap(c_wrap2), .load_err(c_err2)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int d, input bit w, input bit e, input bit t);
    chk({tag, ".data"}, 32'(data_out), d);
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".err"},  32'(load_err), 32'(e));
    chk({tag, ".tc"},   32'(tc), 32'(t));
  endtask

  int m1, m2, wrap2_cnt;
  bit inc2, w2;

  initial begin
    reset = 1'b1; en = 1'b1; load = 1'b0; mode = MODE_UP; data_in = 4'd9;
    s_en = 1'b0; s_load = 1'b0; s_mode = MODE_UP; s_data_in = '0;
    f_en = 1'b0; f_load = 1'b0; f_mode = MODE_UP; f_data_in = '0;
    c_en1 = 1'b0; c_din = '0;

    // Reset state
    step();
    chk_main("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset.sat_data", 32'(s_data_out), 0);
    chk("reset.full_data", 32'(f_data_out), 0);

    // Count up through a full cycle: 1..11, 0 with wrap on the return to 0
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_main($sformatf("up%0d", i), i % 12, i == 12, 1'b0, (i % 12) == 11);
    end

    // Load 3 then count down: 2,1,0,11,10
    load = 1'b1; en = 1'b0; data_in = 4'd3;
    step();
    chk_main("load3", 3, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; mode = MODE_DOWN;
    step(); chk_main("dn2", 2, 1'b0, 1'b0, 1'b0);
    step(); chk_main("dn1", 1, 1'b0, 1'b0, 1'b0);
    step(); chk_main("dn0", 0, 1'b0, 1'b0, 1'b1);
    step(); chk_main("dn11", 11, 1'b1, 1'b0, 1'b0);
    step(); chk_main("dn10", 10, 1'b0, 1'b0, 1'b0);

    // Out-of-range load clamps to 11 and pulses load_err once
    load = 1'b1; en = 1'b0; data_in = 4'd14;
    step(); chk_main("load14", 11, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    step(); chk_main("hold_after14", 11, 1'b0, 1'b0, 1'b0);
    load = 1'b1; data_in = 4'd11;
    step(); chk_main("load11", 11, 1'b0, 1'b0, 1'b0);
    // tc follows mode without a clock edge
    mode = MODE_UP; #1;
    chk("tc_mode_up", 32'(tc), 1);

    // load beats en; reset beats load
    load = 1'b1; en = 1'b1; data_in = 4'd5;
    step(); chk_main("load_en5", 5, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; data_in = 4'd7;
    step(); chk_main("reset_load", 0, 1'b0, 1'b0, 1'b0);

    // Hold, then down-wrap from 0
    reset = 1'b0; load = 1'b0; en = 1'b0;
    step(); chk_main("hold0", 0, 1'b0, 1'b0, 1'b0);
    en = 1'b1; mode = MODE_DOWN;
    step(); chk_main("dnwrap", 11, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    step(); chk_main("hold11", 11, 1'b0, 1'b0, 1'b0);

    // Saturating instance
    s_load = 1'b1; s_data_in = 4'd10;
    step(); chk("sat.load10", 32'(s_data_out), 10);
    s_load = 1'b0; s_en = 1'b1; s_mode = MODE_UP;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("sat.up%0d.data", i), 32'(s_data_out), 11);
      chk($sformatf("sat.up%0d.wrap", i), 32'(s_wrap), 0);
      chk($sformatf("sat.up%0d.tc", i), 32'(s_tc), 1);
    end
    s_load = 1'b1; s_en = 1'b0; s_data_in = 4'd1; s_mode = MODE_DOWN;
    step(); chk("sat.load1", 32'(s_data_out), 1);
    s_load = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("sat.dn%0d.data", i), 32'(s_data_out), 0);
      chk($sformatf("sat.dn%0d.wrap", i), 32'(s_wrap), 0);
      chk($sformatf("sat.dn%0d.tc", i), 32'(s_tc), 1);
    end
    s_en = 1'b0;

    // Full-range modulus: 15 is a legal load and up-wraps naturally to 0
    f_load = 1'b1; f_data_in = 4'd15;
    step();
    chk("full.load15", 32'(f_data_out), 15);
    chk("full.err", 32'(f_load_err), 0);
    chk("full.tc", 32'(f_tc), 1);
    f_load = 1'b0; f_en = 1'b1;
    step();
    chk("full.wrap_data", 32'(f_data_out), 0);
    chk("full.wrap", 32'(f_wrap), 1);
    f_en = 1'b0;

    // Cascade from reset: 144 up-counts return both stages to 0
    reset = 1'b1;
    step();
    reset = 1'b0; c_en1 = 1'b1;
    m1 = 0; m2 = 0; wrap2_cnt = 0;
    for (int i = 1; i <= 144; i++) begin
      inc2 = (m1 == 11);
      m1 = (m1 + 1) % 12;
      w2 = inc2 && (m2 == 11);
      if (inc2) m2 = (m2 + 1) % 12;
      step();
      chk($sformatf("casc%0d.q1", i), 32'(c_q1), m1);
      chk($sformatf("casc%0d.q2", i), 32'(c_q2), m2);
      chk($sformatf("casc%0d.w2", i), 32'(c_wrap2), 32'(w2));
      if (c_wrap2) wrap2_cnt++;
    end
    c_en1 = 1'b0;
    chk("casc.final_q1", 32'(c_q1), 0);
    chk("casc.final_q2", 32'(c_q2), 0);
    chk("casc.wrap2_count", 32'(wrap2_cnt), 1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
